// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared pixel-mode enum, timing-total helper and pixel decoder for the VGA framebuffer controller
package vga_fb_pkg;

    typedef enum logic [1:0] {MODE_MONO, MODE_RGB222, MODE_RGB332, MODE_GREY} mode_e;

    function automatic int total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Returns {R,G,B} as 8-bit MSB-aligned fields; callers keep the top VGA_BITS of each.
    function automatic logic [23:0] decode(input logic [7:0] b, input mode_e m);
        return (m == MODE_MONO)   ? {24{b[0]}} :
               (m == MODE_RGB222) ? {b[5:4], 6'b0, b[3:2], 6'b0, b[1:0], 6'b0} :
               (m == MODE_RGB332) ? {b[7:5], 5'b0, b[4:2], 5'b0, b[1:0], 6'b0} :
                                    {3{b}};
    endfunction

endpackage

// File: rtl/vga_fb_ctrl_timing.sv
// vga_timing: raster x/y counters with sync windows, visible flag, frame_start and vblank
module vga_timing
    import vga_fb_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int XW       = $clog2(total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    parameter int YW       = $clog2(total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          visible,
    output logic          hs,
    output logic          vs,
    output logic          line_end,
    output logic          frame_start,
    output logic          vblank
);

    localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    logic run;

    // counters sit at the origin for one clock after reset so the first frame_start is seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x   <= '0;
            y   <= '0;
            run <= 1'b0;
        end else if (!run) begin
            run <= 1'b1;
        end else begin
            x <= line_end ? '0 : x + XW'(1);
            if (line_end) y <= (y == YW'(V_TOTAL - 1)) ? '0 : y + YW'(1);
        end
    end

    // raster decode, all in the counter domain
    always_comb begin
        line_end    = run && x == XW'(H_TOTAL - 1);
        visible     = run && x < XW'(H_ACTIVE) && y < YW'(V_ACTIVE);
        hs          = run && x >= XW'(H_ACTIVE + H_FP) && x < XW'(H_ACTIVE + H_FP + H_SYNC);
        vs          = run && y >= YW'(V_ACTIVE + V_FP) && y < YW'(V_ACTIVE + V_FP + V_SYNC);
        frame_start = run && x == '0 && y == '0;
        vblank      = y >= YW'(V_ACTIVE);
    end

endmodule

// File: rtl/vga_fb_ctrl.sv
// vga_fb_ctrl: parametrised VGA raster + framebuffer reader; `VGA_FB_TESTPAT_EN adds test_en colour bars
module vga_fb_ctrl
    import vga_fb_pkg::*;
#(
    parameter int VGA_BITS   = 8,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SCALE_LOG2 = 1,
    parameter int MEM_LAT    = 1,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         fb_base,
    input  logic [1:0]          mode,
    input  logic [31:0]         vdata,
`ifdef VGA_FB_TESTPAT_EN
    input  logic                test_en,
`endif
    output logic [31:0]         vaddr,
    output logic                vrd,
    output logic [VGA_BITS-1:0] VGA_R,
    output logic [VGA_BITS-1:0] VGA_G,
    output logic [VGA_BITS-1:0] VGA_B,
    output logic                VGA_HS_O,
    output logic                VGA_VS_O,
    output logic                frame_start,
    output logic                vblank
);

    localparam int          V_TOTAL  = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int          XW       = $clog2(total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int          YW       = $clog2(V_TOTAL);
    localparam logic [31:0] FB_W     = 32'(H_ACTIVE >> SCALE_LOG2);
    localparam logic [31:0] ROW_MASK = 32'((1 << SCALE_LOG2) - 1);

    logic [XW-1:0]       x;
    logic [YW-1:0]       y;
    logic                visible, hs, vs, line_end, rd_next;
    logic [31:0]         base_active, row_base, byte_addr;
    mode_e               mode_active;
    logic [MEM_LAT:0]    vis_d, hs_d, vs_d;
    logic [1:0]          lane_d [MEM_LAT+1];
    logic [7:0]          pix;
    logic [23:0]         rgb;
    logic [VGA_BITS-1:0] r_c, g_c, b_c;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .XW(XW), .YW(YW)
    ) u_timing (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .visible(visible), .hs(hs), .vs(vs),
        .line_end(line_end), .frame_start(frame_start), .vblank(vblank)
    );

    assign byte_addr = base_active + row_base + 32'(x >> SCALE_LOG2);

`ifdef VGA_FB_TESTPAT_EN
    logic [MEM_LAT:0] tp_d;
    logic [2:0]       bar_d [MEM_LAT+1];
    assign rd_next = visible && !test_en;

    // bar index and test-pattern select ride alongside the memory pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tp_d <= '0;
            for (int i = 0; i <= MEM_LAT; i++) bar_d[i] <= '0;
        end else begin
            tp_d     <= {tp_d[MEM_LAT-1:0], test_en};
            bar_d[0] <= 3'(32'(x) / (H_ACTIVE / 8));
            for (int i = 1; i <= MEM_LAT; i++) bar_d[i] <= bar_d[i-1];
        end
    end
`else
    assign rd_next = visible;
`endif

    // new base and mode take effect only at the start of vblank, so a frame never tears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_active <= '0;
            mode_active <= MODE_MONO;
        end else if (x == '0 && y == YW'(V_ACTIVE)) begin
            base_active <= fb_base;
            mode_active <= mode_e'(mode);
        end
    end

    // row offset steps by one framebuffer row every 2**SCALE_LOG2 lines, zeroed entering a new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) row_base <= '0;
        else if (line_end)
            row_base <= (y == YW'(V_TOTAL - 1)) ? '0 :
                        (y < YW'(V_ACTIVE) && ((32'(y) + 32'd1) & ROW_MASK) == '0) ? row_base + FB_W : row_base;
    end

    // memory request plus MEM_LAT+1 stage delay line that lands in step with vdata
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vaddr <= '0;
            vrd   <= 1'b0;
            vis_d <= '0;
            hs_d  <= '0;
            vs_d  <= '0;
            for (int i = 0; i <= MEM_LAT; i++) lane_d[i] <= '0;
        end else begin
            vaddr     <= {2'b00, byte_addr[31:2]};
            vrd       <= rd_next;
            vis_d     <= {vis_d[MEM_LAT-1:0], visible};
            hs_d      <= {hs_d[MEM_LAT-1:0], hs};
            vs_d      <= {vs_d[MEM_LAT-1:0], vs};
            lane_d[0] <= byte_addr[1:0];
            for (int i = 1; i <= MEM_LAT; i++) lane_d[i] <= lane_d[i-1];
        end
    end

    // pick the addressed byte and expand it to channel colours
    always_comb begin
        pix = 8'(vdata >> {lane_d[MEM_LAT], 3'b000});
        rgb = decode(pix, mode_active);
        r_c = rgb[23 -: VGA_BITS];
        g_c = rgb[15 -: VGA_BITS];
        b_c = rgb[7 -: VGA_BITS];
`ifdef VGA_FB_TESTPAT_EN
        if (tp_d[MEM_LAT]) begin
            r_c = {VGA_BITS{bar_d[MEM_LAT][2]}};
            g_c = {VGA_BITS{bar_d[MEM_LAT][1]}};
            b_c = {VGA_BITS{bar_d[MEM_LAT][0]}};
        end
`endif
    end

    // registered pins: blanked colour and syncs at the configured polarity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            VGA_R    <= '0;
            VGA_G    <= '0;
            VGA_B    <= '0;
            VGA_HS_O <= ~SYNC_POL;
            VGA_VS_O <= ~SYNC_POL;
        end else begin
            VGA_R    <= vis_d[MEM_LAT] ? r_c : '0;
            VGA_G    <= vis_d[MEM_LAT] ? g_c : '0;
            VGA_B    <= vis_d[MEM_LAT] ? b_c : '0;
            VGA_HS_O <= hs_d[MEM_LAT] ? SYNC_POL : ~SYNC_POL;
            VGA_VS_O <= vs_d[MEM_LAT] ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// tb_vga_fb_ctrl: two small-raster instances checked every clock against a position-based reference model
module tb_vga_fb_ctrl;

    localparam int HA = 32, HFP = 4, HSW = 6, HBP = 6;
    localparam int VA = 8, VFP = 2, VSW = 2, VBP = 2;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FT = HT * VT;
    localparam int HSS = HA + HFP, HSE = HA + HFP + HSW;
    localparam int VSS = VA + VFP, VSE = VA + VFP + VSW;
    localparam int HN = 32768;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] fb_base = '0;
    logic [1:0]  mode = '0;
    logic [31:0] vdata_a, vdata_b, a_vaddr, b_vaddr;
    logic        a_vrd, b_vrd, a_hs, a_vs, b_hs, b_vs, a_fs, b_fs, a_vb, b_vb;
    logic [7:0]  a_r, a_g, a_b;
    logic [3:0]  b_r, b_g, b_b;

    vga_fb_ctrl #(.VGA_BITS(8), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SCALE_LOG2(1), .MEM_LAT(1), .SYNC_POL(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .fb_base(fb_base), .mode(mode), .vdata(vdata_a),
        .vaddr(a_vaddr), .vrd(a_vrd), .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b),
        .VGA_HS_O(a_hs), .VGA_VS_O(a_vs), .frame_start(a_fs), .vblank(a_vb));

    vga_fb_ctrl #(.VGA_BITS(4), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SCALE_LOG2(0), .MEM_LAT(3), .SYNC_POL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .fb_base(fb_base), .mode(mode), .vdata(vdata_b),
        .vaddr(b_vaddr), .vrd(b_vrd), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
        .VGA_HS_O(b_hs), .VGA_VS_O(b_vs), .frame_start(b_fs), .vblank(b_vb));

    always #5 clk = ~clk;

    // memory: 256 words indexed by the low word-address bits, returned MEM_LAT clocks after the request
    logic [31:0] mem [256];
    logic [31:0] ap_a [1];
    logic [31:0] ap_b [3];
    always @(posedge clk) begin
        ap_a[0] <= a_vaddr;
        ap_b[0] <= b_vaddr;
        ap_b[1] <= ap_b[0];
        ap_b[2] <= ap_b[1];
    end
    assign vdata_a = mem[ap_a[0][7:0]];
    assign vdata_b = mem[ap_b[2][7:0]];

    int chk = 0, fails = 0, cnt = 0;
    int act_base = 0, act_mode = 0;
    int base_hist [HN];
    int mode_hist [HN];
    bit rnd = 1'b0;

    typedef struct packed {
        logic [1:0] m;
        logic [7:0] byt, r, g, b;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cnt=%0d actual=%h expected=%h", nm, cnt, act, exp);
        end
    endtask

    function automatic bit vis(input int q);
        return ((q % FT) % HT) < HA && ((q % FT) / HT) < VA;
    endfunction

    function automatic int exp_addr(input int q, input int s);
        int xq = (q % FT) % HT, yq = (q % FT) / HT;
        return base_hist[q] + (yq >> s) * (HA >> s) + (xq >> s);
    endfunction

    function automatic logic [23:0] exp_rgb(input int q, input int s);
        int a = exp_addr(q, s);
        int b = int'((mem[(a >> 2) & 255] >> (8 * (a % 4))) & 32'hFF);
        int r, g, bl;
        case (mode_hist[q])
            0: begin r = (b & 1) ? 255 : 0; g = r; bl = r; end
            1: begin r = ((b >> 4) & 3) << 6; g = ((b >> 2) & 3) << 6; bl = (b & 3) << 6; end
            2: begin r = ((b >> 5) & 7) << 5; g = ((b >> 2) & 7) << 5; bl = (b & 3) << 6; end
            default: begin r = b; g = b; bl = b; end
        endcase
        return {8'(r), 8'(g), 8'(bl)};
    endfunction

    task automatic inst_check(input string nm, input int lat, input int s, input int vb, input bit pol,
                              input logic rd, input logic [31:0] va, input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input logic hs, input logic vs, input logic fs, input logic vbk);
        int p = cnt - 1;
        int q = p - 1;
        logic [7:0] mask = 8'hFF << (8 - vb);
        logic [23:0] e = '0;
        bit ehs = !pol, evs = !pol;
        check({nm, "_frame_start"}, {31'b0, fs}, {31'b0, (p % FT) == 0});
        check({nm, "_vblank"}, {31'b0, vbk}, {31'b0, ((p % FT) / HT) >= VA});
        check({nm, "_vrd"}, {31'b0, rd}, {31'b0, q >= 0 && vis(q)});
        if (q >= 0 && vis(q)) check({nm, "_vaddr"}, va, 32'(exp_addr(q, s) >> 2));
        q = p - (lat + 2);
        if (q >= 0) begin
            if (vis(q)) e = exp_rgb(q, s);
            ehs = (((q % FT) % HT) >= HSS && ((q % FT) % HT) < HSE) ? pol : !pol;
            evs = (((q % FT) / HT) >= VSS && ((q % FT) / HT) < VSE) ? pol : !pol;
        end
        check({nm, "_rgb"}, {8'h0, r, g, b}, {8'h0, e[23:16] & mask, e[15:8] & mask, e[7:0] & mask});
        check({nm, "_hs"}, {31'b0, hs}, {31'b0, ehs});
        check({nm, "_vs"}, {31'b0, vs}, {31'b0, evs});
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            if (cnt > 0 && ((cnt - 1) % FT) == VA * HT) begin
                act_base = int'(fb_base);
                act_mode = int'(mode);
            end
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (cnt - 1 >= HN) begin
                $display("FAIL history_overflow cnt=%0d limit=%0d", cnt, HN);
                $fatal(1);
            end
            base_hist[cnt-1] = act_base;
            mode_hist[cnt-1] = act_mode;
            inst_check("A", 1, 1, 8, 1'b0, a_vrd, a_vaddr, a_r, a_g, a_b, a_hs, a_vs, a_fs, a_vb);
            inst_check("B", 3, 0, 4, 1'b1, b_vrd, b_vaddr, {b_r, 4'h0}, {b_g, 4'h0}, {b_b, 4'h0}, b_hs, b_vs, b_fs, b_vb);
            if (rnd && $urandom_range(0, 31) == 0) begin
                fb_base = 32'($urandom_range(0, 65535));
                mode    = 2'($urandom_range(0, 3));
            end
        end
    endtask

    task automatic wait_pos(input int px, input int py);
        int n = 0;
        run_cycles(1);
        while (((cnt - 1) % FT) != py * HT + px && n < 2 * FT) begin
            run_cycles(1);
            n++;
        end
        if (n >= 2 * FT) begin
            chk++;
            fails++;
            $display("FAIL wait_pos actual=timeout required=x%0d_y%0d", px, py);
        end
    endtask

    task automatic reset_outs(input string nm);
        check({nm, "_vrd"}, {31'b0, a_vrd}, 32'd0);
        check({nm, "_vaddr"}, a_vaddr, 32'd0);
        check({nm, "_rgb_a"}, {8'h0, a_r, a_g, a_b}, 32'd0);
        check({nm, "_rgb_b"}, {20'h0, b_r, b_g, b_b}, 32'd0);
        check({nm, "_syncs"}, {28'h0, a_hs, a_vs, b_hs, b_vs}, 32'b1100);
        check({nm, "_fs_vb"}, {28'h0, a_fs, a_vb, b_fs, b_vb}, 32'd0);
    endtask

    task automatic fill_mem(input bit random, input logic [7:0] b);
        for (int i = 0; i < 256; i++) mem[i] = random ? $urandom : {4{b}};
    endtask

    initial begin
        int first = -1, width = -1, nxt = -1;
        tbl[0] = '{2'd0, 8'h01, 8'hFF, 8'hFF, 8'hFF};
        tbl[1] = '{2'd0, 8'hFE, 8'h00, 8'h00, 8'h00};
        tbl[2] = '{2'd1, 8'h36, 8'hC0, 8'h40, 8'h80};
        tbl[3] = '{2'd2, 8'hE3, 8'hE0, 8'h00, 8'hC0};
        tbl[4] = '{2'd3, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        tbl[5] = '{2'd2, 8'h5A, 8'h40, 8'hC0, 8'h80};
        fill_mem(1'b1, 8'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_outs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 200 && first < 0; i++) begin
            run_cycles(1);
            if (a_hs == 1'b0) first = cnt - 1;
        end
        check("hs_first", first, 32'(HSS + 3));
        for (int i = 0; i < 100 && width < 0; i++) begin
            run_cycles(1);
            if (a_hs == 1'b1) width = cnt - 1 - first;
        end
        check("hs_width", width, 32'(HSW));
        for (int i = 0; i < 100 && nxt < 0; i++) begin
            run_cycles(1);
            if (a_hs == 1'b0) nxt = cnt - 1;
        end
        check("line_period", nxt - first, 32'(HT));

        rnd = 1'b1;
        run_cycles(3 * FT);
        rnd = 1'b0;

        wait_pos(HA + 8, VA - 1);
        fb_base = 32'h0;
        wait_pos(0, 3);
        fb_base = 32'h8000;
        wait_pos(1, 5);
        check("old_base_a", a_vaddr, 32'd8);
        check("old_base_b", b_vaddr, 32'd40);
        wait_pos(1, 0);
        check("new_base_a", a_vaddr, 32'h2000);
        check("new_base_b", b_vaddr, 32'h2000);

        for (int i = 0; i < 6; i++) begin
            wait_pos(HA + 8, VA - 1);
            mode = tbl[i].m;
            fill_mem(1'b0, tbl[i].byt);
            wait_pos(4 + 3, 2);
            check($sformatf("tbl%0d_a", i), {8'h0, a_r, a_g, a_b}, {8'h0, tbl[i].r, tbl[i].g, tbl[i].b});
            wait_pos(4 + 5, 2);
            check($sformatf("tbl%0d_b", i), {20'h0, b_r, b_g, b_b}, {20'h0, tbl[i].r[7:4], tbl[i].g[7:4], tbl[i].b[7:4]});
        end
        wait_pos(HA + 8, VA - 1);
        fill_mem(1'b1, 8'h0);
        rnd = 1'b1;
        run_cycles(FT);
        rnd = 1'b0;

        wait_pos(20, 5);
        rst_n = 1'b0;
        #1;
        reset_outs("midreset");
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_outs("held_reset");
        rst_n    = 1'b1;
        cnt      = 0;
        act_base = 0;
        act_mode = 0;
        run_cycles(1);
        check("restart_frame_start", {31'b0, a_fs}, 32'd1);
        run_cycles(1);
        check("restart_vaddr", a_vaddr, 32'd0);
        check("restart_vrd", {31'b0, a_vrd}, 32'd1);
        rnd = 1'b1;
        run_cycles(FT + 50);

        $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
        $finish;
    end

endmodule
